branch_history_table: RTL
=========================

BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 Parameter IDX_W, default 6, SHALL set index width; the table SHALL hold 2^IDX_W entries.
REQ-002 Parameter TAG_W, default 8, SHALL set partial-tag width; it SHALL be used only when BHT_TAG_EN is defined.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 rstn  input  1  SHALL be the synchronous, active-low reset.
REQ-005 lookup_valid  input  1  SHALL indicate that the IF stage presents a new fetch PC this cycle.
REQ-006 lookup_pc  input  `WORD  SHALL carry the fetch PC to predict.
REQ-007 predict  output  1  SHALL be the registered taken-prediction feeding the IF-stage pre-branch logic.
REQ-008 predict_hit  output  1  SHALL be the registered tag-hit flag; it SHALL be constant 1 when BHT_TAG_EN is undefined.
REQ-009 upd_valid  input  1  SHALL indicate that EX has resolved a branch this cycle.
REQ-010 upd_pc  input  `WORD  SHALL carry the PC of the resolved branch.
REQ-011 upd_taken  input  1  SHALL carry the resolved direction: 1 = taken.

Function
REQ-012 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-013 Each entry SHALL hold a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-014 On upd_valid with upd_taken=1, the indexed counter SHALL increment and saturate at 11.
REQ-015 On upd_valid with upd_taken=0, the indexed counter SHALL decrement and saturate at 00.
REQ-016 Lookup latency SHALL be exactly 1 cycle: lookup_valid at edge N SHALL produce predict and predict_hit after edge N+1, aligned with the ICache instruction.
REQ-017 predict SHALL equal counter[1] of the indexed entry, ANDed with tag hit when BHT_TAG_EN is defined.
REQ-018 While lookup_valid=0, predict and predict_hit SHALL hold their previous values (IF stall).
REQ-019 If lookup and update target the same index in the same cycle, the registered prediction SHALL reflect the post-update entry state (write-first bypass).
REQ-020 Updates to different indices SHALL not disturb any other entry, and lookups SHALL never modify table state.
REQ-021 No handshake back-pressure SHALL exist: every valid lookup and every valid update SHALL be accepted in the same cycle.

Reset
REQ-022 While rstn=0 at a clock edge, all counters SHALL become 01, all valid bits SHALL become 0, predict SHALL become 0, and predict_hit SHALL become 0 (1 when BHT_TAG_EN is undefined).
REQ-023 Reset SHALL take priority over a simultaneous lookup or update, and that update SHALL be discarded.
REQ-024 The first lookup after reset release SHALL predict not-taken.

Configuration
REQ-025 Macro BHT_TAG_EN defined: each entry SHALL add a valid bit and a TAG_W tag, and a lookup hit SHALL require valid=1 and a tag match.
REQ-026 With BHT_TAG_EN defined, an update that hits SHALL saturate-update the counter, and an update that misses SHALL allocate the entry: valid=1, tag written, counter=10 if taken, else 01.
REQ-027 With BHT_TAG_EN defined, a lookup miss SHALL drive predict=0 and predict_hit=0.
REQ-028 Macro BHT_TAG_EN undefined: no tag or valid storage SHALL exist, every update SHALL saturate-update the indexed counter, and predict_hit SHALL be 1.

Verification
REQ-029 Reset, then lookup 0x1C000000 -> predict=0 one cycle later, predict_hit=0 (tag mode).
REQ-030 Three taken updates to 0x1C000010, then a lookup -> predict=1; four not-taken updates, then a lookup -> predict=0, with the counter saturated at 00.
REQ-031 Same-cycle update (taken) and lookup at 0x1C000020 with the counter at 01 -> predict=1 on the next cycle.
REQ-032 Lookup 0x1C000010, then lookup_valid=0 for 3 cycles while other entries are updated -> predict holds its value.
REQ-033 Tag mode: allocate 0x1C000040 as taken, then look up alias 0x1C000140 (same index, different tag) -> predict=0, predict_hit=0; the taken update to the alias then replaces the entry.
REQ-034 Assert rstn=0 during an update of a strong-T entry -> after release, that entry predicts 0.

Source files
------------

// File: rtl/branch_history_table.sv
// branch_history_table
//   Direct-mapped table of 2-bit saturating branch-direction counters with a
//   one-cycle registered lookup and a write-first bypass from the update port.
//
//   Optional feature macro: BHT_TAG_EN
//     When defined, every entry also carries a valid bit and a TAG_W partial
//     tag. A lookup hits only on a valid entry with a matching tag. An update
//     that misses allocates the entry.
//     When undefined, there is no tag or valid storage and predict_hit is 1.
//
//   Ports
//     clk          : single clock, all state changes on its rising edge
//     rstn         : synchronous active-low reset
//     lookup_valid : IF stage presents a new fetch PC this cycle
//     lookup_pc    : fetch PC to predict
//     predict      : registered taken prediction (held while lookup_valid=0)
//     predict_hit  : registered tag-hit flag (constant 1 without BHT_TAG_EN)
//     upd_valid    : EX resolved a branch this cycle
//     upd_pc       : PC of the resolved branch
//     upd_taken    : resolved direction, 1 = taken
`ifndef WORD
`define WORD 31:0
`endif

module branch_history_table #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         lookup_valid,
    input  logic [`WORD] lookup_pc,
    output logic         predict,
    output logic         predict_hit,
    input  logic         upd_valid,
    input  logic [`WORD] upd_pc,
    input  logic         upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int PC_W    = $bits(lookup_pc);

    // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && cnt != 2'b11)
            res = cnt + 2'b01;
        else if (!taken && cnt != 2'b00)
            res = cnt - 2'b01;
        return res;
    endfunction

    logic [1:0]       cnt_tbl [ENTRIES];
    logic [IDX_W-1:0] idx_l;
    logic [IDX_W-1:0] idx_u;
    logic             bypass;
    logic [1:0]       upd_cnt;
    logic [1:0]       look_cnt;
    logic             look_hit;

    assign idx_l  = lookup_pc[IDX_W+1:2];
    assign idx_u  = upd_pc[IDX_W+1:2];
    assign bypass = upd_valid && (idx_u == idx_l);

`ifdef BHT_TAG_EN
    logic             vld_tbl [ENTRIES];
    logic [TAG_W-1:0] tag_tbl [ENTRIES];
    logic [TAG_W-1:0] tag_l;
    logic [TAG_W-1:0] tag_u;
    logic             upd_hit;
    logic             hit_p1;

    assign tag_l = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign tag_u = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+TAG_W+2], lookup_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+TAG_W+2], upd_pc[1:0]};

    always_comb begin
        upd_hit = vld_tbl[idx_u] && (tag_tbl[idx_u] == tag_u);
        upd_cnt = sat_update(cnt_tbl[idx_u], upd_taken);
        // A missing update allocates with a weak counter toward its direction.
        if (!upd_hit)
            upd_cnt = upd_taken ? 2'b10 : 2'b01;
        // Write-first: a same-index update is seen as if already written.
        if (bypass) begin
            look_cnt = upd_cnt;
            look_hit = (tag_u == tag_l);
        end else begin
            look_cnt = cnt_tbl[idx_l];
            look_hit = vld_tbl[idx_l] && (tag_tbl[idx_l] == tag_l);
        end
    end

    assign predict_hit = hit_p1;
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0], (TAG_W > 0)};

    always_comb begin
        upd_cnt  = sat_update(cnt_tbl[idx_u], upd_taken);
        look_cnt = bypass ? upd_cnt : cnt_tbl[idx_l];
        look_hit = 1'b1;
    end

    assign predict_hit = 1'b1;
`endif

    // ---- stage p0 -> p1: table write and registered prediction ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_tbl[i] <= 2'b01;
`ifdef BHT_TAG_EN
                vld_tbl[i] <= 1'b0;
`endif
            end
            predict <= 1'b0;
`ifdef BHT_TAG_EN
            hit_p1  <= 1'b0;
`endif
        end else begin
            if (upd_valid) begin
                cnt_tbl[idx_u] <= upd_cnt;
`ifdef BHT_TAG_EN
                vld_tbl[idx_u] <= 1'b1;
                tag_tbl[idx_u] <= tag_u;
`endif
            end
            // Without a new fetch the outputs hold for the stalled IF stage.
            if (lookup_valid) begin
                predict <= look_cnt[1] & look_hit;
`ifdef BHT_TAG_EN
                hit_p1  <= look_hit;
`endif
            end
        end
    end

endmodule
